// File: rtl/silife_spi_shifter_if.sv
`default_nettype none
// ============================================================================
// silife_spi_shifter_if : word/start request and SPI output bundle.
// Revision 1.0
// ============================================================================
interface silife_spi_shifter_if #(
   parameter int WORD_BITS = 16
) ();
   logic [WORD_BITS-1:0] i_word;
   logic                 i_start;
   logic                 o_sck;
   logic                 o_mosi;
   logic                 o_busy;
   logic                 o_done;

   modport master (
      output i_word,
      output i_start,
      input  o_sck,
      input  o_mosi,
      input  o_busy,
      input  o_done
   );

   modport slave (
      input  i_word,
      input  i_start,
      output o_sck,
      output o_mosi,
      output o_busy,
      output o_done
   );
endinterface
`default_nettype wire

// File: rtl/silife_spi_shifter.sv
`default_nettype none
// ============================================================================
// silife_spi_shifter : MSB-first SPI transmit shifter, CPOL=0, flop outputs.
// Revision 1.0
// ============================================================================
module silife_spi_shifter #(
   parameter int WORD_BITS = 16,
   parameter int HALF_DIV  = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   silife_spi_shifter_if.slave  bus
);
   localparam int             CW        = $clog2(WORD_BITS);
   localparam logic [CW-1:0]  LAST_BIT  = CW'(WORD_BITS - 1);
   localparam logic [7:0]     LAST_HALF = 8'(HALF_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

   state_t               state, state_nx;
   logic [WORD_BITS-1:0] shreg, shreg_nx;
   logic [CW-1:0]        bit_cnt, bit_nx;
   logic [7:0]           half_cnt, half_nx;
   logic                 sck, sck_nx;
   logic                 mosi, mosi_nx;
   logic                 busy, busy_nx;
   logic                 done, done_nx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         half_cnt <= '0;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         shreg    <= shreg_nx;
         bit_cnt  <= bit_nx;
         half_cnt <= half_nx;
         sck      <= sck_nx;
         mosi     <= mosi_nx;
         busy     <= busy_nx;
         done     <= done_nx;
      end
   end

   // Every output is computed one cycle ahead so it can leave straight from a flop.
   always_comb begin
      state_nx = state;
      shreg_nx = shreg;
      bit_nx   = bit_cnt;
      half_nx  = half_cnt;
      sck_nx   = sck;
      mosi_nx  = mosi;
      busy_nx  = busy;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            sck_nx  = 1'b0;
            mosi_nx = 1'b0;
            busy_nx = 1'b0;
            if (bus.i_start) begin
               shreg_nx = bus.i_word;
               mosi_nx  = bus.i_word[WORD_BITS-1];
               busy_nx  = 1'b1;
               bit_nx   = '0;
               half_nx  = '0;
               state_nx = LOW;
            end
         end
         LOW: begin
            if (half_cnt == LAST_HALF) begin
               half_nx  = '0;
               sck_nx   = 1'b1;
               state_nx = HIGH;
            end else begin
               half_nx = half_cnt + 8'd1;
            end
         end
         HIGH: begin
            if (half_cnt == LAST_HALF) begin
               half_nx = '0;
               sck_nx  = 1'b0;
               if (bit_cnt == LAST_BIT) begin
                  state_nx = IDLE;
                  mosi_nx  = 1'b0;
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
                  shreg_nx = '0;
                  bit_nx   = '0;
               end else begin
                  // Data moves on the falling edge, half a period away from the sampling edge.
                  bit_nx   = bit_cnt + CW'(1);
                  shreg_nx = {shreg[WORD_BITS-2:0], 1'b0};
                  mosi_nx  = shreg[WORD_BITS-2];
                  state_nx = LOW;
               end
            end else begin
               half_nx = half_cnt + 8'd1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.o_sck  = sck;
   assign bus.o_mosi = mosi;
   assign bus.o_busy = busy;
   assign bus.o_done = done;
endmodule
`default_nettype wire
